// File: rtl/gpu_fill_pkg.sv
// Shared definitions for the GPU fill engine: slave register indices, fill
// mode and FSM state encodings, the latched fill-bounds record and a clamp
// helper used when a rectangle overhangs the framebuffer edge.
package gpu_fill_pkg;

  // Slave register map (word index on SLAVE_address)
  localparam logic [3:0] REG_CTRL     = 4'd0;  // bit0 start (rising edge launches a fill)
  localparam logic [3:0] REG_STATUS   = 4'd1;  // bit0 done, bit1 busy; any write clears done
  localparam logic [3:0] REG_COLOR    = 4'd2;
  localparam logic [3:0] REG_X0       = 4'd3;
  localparam logic [3:0] REG_Y0       = 4'd4;
  localparam logic [3:0] REG_X1       = 4'd5;
  localparam logic [3:0] REG_Y1       = 4'd6;
  localparam logic [3:0] REG_MODE     = 4'd7;
  localparam logic [3:0] REG_PIXCOUNT = 4'd8;  // read-only

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_CLEAR = 2'd1,
    MODE_RECT  = 2'd2
  } fill_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_DONE
  } fill_state_e;

  // Inclusive pixel bounds of one fill
  typedef struct packed {
    logic [31:0] x0;
    logic [31:0] y0;
    logic [31:0] x1;
    logic [31:0] y1;
  } fill_bounds_t;

  function automatic logic [31:0] clamp_max(input logic [31:0] value,
                                            input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/gpu_fill_engine_if.sv
// Bus bundle of the GPU fill engine: the register slave port used by the CPU
// and the pixel write master port that streams into the framebuffer.
// Modport 'slave' is the engine's view (it is the register slave and drives
// the pixel master signals); modport 'master' is the system/host view.
//   SLAVE_read/write/chipselect  register access strobes
//   SLAVE_address[3:0]           register word index
//   SLAVE_writedata/readdata     32-bit register data
//   MASTER_write                 pixel write request
//   MASTER_address[31:0]         pixel byte address
//   MASTER_writedata[31:0]       pixel colour
//   MASTER_waitrequest           interconnect stall, holds the current pixel
interface gpu_fill_engine_if;
  logic        SLAVE_read;
  logic        SLAVE_write;
  logic        SLAVE_chipselect;
  logic [3:0]  SLAVE_address;
  logic [31:0] SLAVE_writedata;
  logic [31:0] SLAVE_readdata;

  logic        MASTER_write;
  logic [31:0] MASTER_address;
  logic [31:0] MASTER_writedata;
  logic        MASTER_waitrequest;

  modport slave (
    input  SLAVE_read, SLAVE_write, SLAVE_chipselect, SLAVE_address, SLAVE_writedata,
    output SLAVE_readdata,
    output MASTER_write, MASTER_address, MASTER_writedata,
    input  MASTER_waitrequest
  );

  modport master (
    output SLAVE_read, SLAVE_write, SLAVE_chipselect, SLAVE_address, SLAVE_writedata,
    input  SLAVE_readdata,
    input  MASTER_write, MASTER_address, MASTER_writedata,
    output MASTER_waitrequest
  );
endinterface

// File: rtl/fill_raster_counter.sv
// Raster walker for a fill: x runs fastest from x_start to x_end, then y
// steps. The byte offset of the current pixel is kept as a row offset plus a
// column offset, both advanced by constant strides, so the pixel loop needs
// only adders. The multiplies happen once, at load.
//   CLK, RESET      clock, asynchronous active-high reset
//   load            capture bounds and position on the first pixel
//   advance         step to the next pixel in raster order
//   x_start..y_end  inclusive bounds (already clamped by the caller)
//   x, y            current pixel coordinates
//   offset          (y*H_RES + x)*BPP_BYTES for the current pixel
//   last            current pixel is the final pixel of the fill
module fill_raster_counter #(
  parameter int H_RES     = 640,
  parameter int BPP_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] x_start,
  input  logic [31:0] y_start,
  input  logic [31:0] x_end,
  input  logic [31:0] y_end,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] offset,
  output logic        last
);

  localparam logic [31:0] ROW_STRIDE = 32'(H_RES * BPP_BYTES);
  localparam logic [31:0] COL_STRIDE = 32'(BPP_BYTES);

  logic [31:0] x_first, x_last, y_last;
  logic [31:0] row_off, col_off, col_first;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would let later lines see new values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x         <= '0;
      y         <= '0;
      x_first   <= '0;
      x_last    <= '0;
      y_last    <= '0;
      row_off   <= '0;
      col_off   <= '0;
      col_first <= '0;
    end else if (load) begin
      x         <= x_start;
      y         <= y_start;
      x_first   <= x_start;
      x_last    <= x_end;
      y_last    <= y_end;
      row_off   <= y_start * ROW_STRIDE;
      col_first <= x_start * COL_STRIDE;
      col_off   <= x_start * COL_STRIDE;
    end else if (advance) begin
      if (x == x_last) begin
        x       <= x_first;
        y       <= y + 32'd1;
        col_off <= col_first;
        row_off <= row_off + ROW_STRIDE;
      end else begin
        x       <= x + 32'd1;
        col_off <= col_off + COL_STRIDE;
      end
    end
  end

  assign offset = row_off + col_off;
  assign last   = (x == x_last) && (y == y_last);

endmodule

// File: rtl/gpu_fill_engine.sv
// GPU fill engine: a register-programmed block that writes a solid colour
// over the whole framebuffer (clear) or over an inclusive rectangle (rect),
// one pixel per cycle on the master port when not stalled.
//   CLK, RESET  clock, asynchronous active-high reset
//   bus         register slave + pixel write master (gpu_fill_engine_if.slave)
//   done        mirrors STATUS.done
module gpu_fill_engine
  import gpu_fill_pkg::*;
#(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter logic [31:0] FB_BASE   = 32'h0,
  parameter int          BPP_BYTES = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  gpu_fill_engine_if.slave   bus,
  output logic               done
);

  localparam logic [31:0] H_LIM = 32'(H_RES);
  localparam logic [31:0] V_LIM = 32'(V_RES);
  localparam logic [31:0] H_MAX = 32'(H_RES - 1);
  localparam logic [31:0] V_MAX = 32'(V_RES - 1);

  fill_state_e  state_q, state_n;
  fill_mode_e   mode_sel;
  fill_bounds_t bounds;
  logic         bounds_ok;

  logic        ctrl_start_q, done_q;
  logic [31:0] color_q, x0_q, y0_q, x1_q, y1_q, mode_q;
  logic [31:0] pixcount_q, fill_color_q, readdata_q, read_mux;

  logic        slave_wr, slave_rd, start_edge, busy, accept, done_set;
  logic        load, advance, last;
  logic [31:0] ras_x, ras_y, ras_offset;

  assign slave_wr   = bus.SLAVE_chipselect && bus.SLAVE_write;
  assign slave_rd   = bus.SLAVE_chipselect && bus.SLAVE_read;
  // Only a 0->1 transition of the stored start bit launches a fill.
  assign start_edge = slave_wr && (bus.SLAVE_address == REG_CTRL) &&
                      bus.SLAVE_writedata[0] && !ctrl_start_q;
  assign busy       = (state_q == ST_SETUP) || (state_q == ST_WRITE);
  assign accept     = (state_q == ST_WRITE) && !bus.MASTER_waitrequest;
  assign load       = (state_q == ST_SETUP);
  assign advance    = accept && !last;

  // Effective bounds of the programmed fill, evaluated while in SETUP.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mode_sel  = MODE_NONE;
    bounds    = '0;
    bounds_ok = 1'b0;
    case (mode_q)
      32'd1:   mode_sel = MODE_CLEAR;
      32'd2:   mode_sel = MODE_RECT;
      default: mode_sel = MODE_NONE;
    endcase
    case (mode_sel)
      MODE_CLEAR: begin
        bounds    = '{x0: 32'd0, y0: 32'd0, x1: H_MAX, y1: V_MAX};
        bounds_ok = 1'b1;
      end
      MODE_RECT: begin
        bounds    = '{x0: x0_q, y0: y0_q,
                      x1: clamp_max(x1_q, H_MAX), y1: clamp_max(y1_q, V_MAX)};
        bounds_ok = (bounds.x0 <= bounds.x1) && (bounds.y0 <= bounds.y1) &&
                    (x0_q < H_LIM) && (y0_q < V_LIM);
      end
      default: bounds_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_n = ST_SETUP;
      ST_SETUP: state_n = bounds_ok ? ST_WRITE : ST_DONE;
      ST_WRITE: if (accept && last) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // done rises on the same edge the FSM enters DONE, which also drops busy.
  assign done_set = (state_n == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Register file; STATUS writes only clear done and lose to a same-cycle set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl_start_q <= 1'b0;
      done_q       <= 1'b0;
      color_q      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      mode_q       <= '0;
    end else begin
      if (slave_wr) begin
        case (bus.SLAVE_address)
          REG_CTRL:  ctrl_start_q <= bus.SLAVE_writedata[0];
          REG_COLOR: color_q      <= bus.SLAVE_writedata;
          REG_X0:    x0_q         <= bus.SLAVE_writedata;
          REG_Y0:    y0_q         <= bus.SLAVE_writedata;
          REG_X1:    x1_q         <= bus.SLAVE_writedata;
          REG_Y1:    y1_q         <= bus.SLAVE_writedata;
          REG_MODE:  mode_q       <= bus.SLAVE_writedata;
          default:   ;
        endcase
      end
      if (done_set)
        done_q <= 1'b1;
      else if (slave_wr && (bus.SLAVE_address == REG_STATUS))
        done_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pixcount_q   <= '0;
      fill_color_q <= '0;
    end else if (load) begin
      pixcount_q   <= '0;
      fill_color_q <= color_q;
    end else if (accept) begin
      pixcount_q   <= pixcount_q + 32'd1;
    end
  end

  always_comb begin
    read_mux = '0;
    case (bus.SLAVE_address)
      REG_CTRL:     read_mux = {31'd0, ctrl_start_q};
      REG_STATUS:   read_mux = {30'd0, busy, done_q};
      REG_COLOR:    read_mux = color_q;
      REG_X0:       read_mux = x0_q;
      REG_Y0:       read_mux = y0_q;
      REG_X1:       read_mux = x1_q;
      REG_Y1:       read_mux = y1_q;
      REG_MODE:     read_mux = mode_q;
      REG_PIXCOUNT: read_mux = pixcount_q;
      default:      read_mux = '0;
    endcase
  end

  // Read data is registered: it appears the cycle after the read is sampled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         readdata_q <= '0;
    else if (slave_rd) readdata_q <= read_mux;
  end

  fill_raster_counter #(
    .H_RES     (H_RES),
    .BPP_BYTES (BPP_BYTES)
  ) u_raster (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (load),
    .advance (advance),
    .x_start (bounds.x0),
    .y_start (bounds.y0),
    .x_end   (bounds.x1),
    .y_end   (bounds.y1),
    .x       (ras_x),
    .y       (ras_y),
    .offset  (ras_offset),
    .last    (last)
  );

  // Master outputs come straight from registered state, so they stay stable
  // while waitrequest stalls and drop to zero the instant reset hits.
  assign bus.MASTER_write     = (state_q == ST_WRITE);
  assign bus.MASTER_address   = (state_q == ST_WRITE) ? (FB_BASE + ras_offset) : 32'd0;
  assign bus.MASTER_writedata = (state_q == ST_WRITE) ? fill_color_q : 32'd0;
  assign bus.SLAVE_readdata   = readdata_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Scoreboard bench for gpu_fill_engine. A 640x32 framebuffer keeps the
// full-clear run short while rectangle addresses match a 640-wide layout.
module tb_gpu_fill_engine;

  localparam int TB_H = 640;
  localparam int TB_V = 32;

  localparam logic [3:0] A_CTRL = 4'd0, A_STATUS = 4'd1, A_COLOR = 4'd2,
                         A_X0 = 4'd3, A_Y0 = 4'd4, A_X1 = 4'd5, A_Y1 = 4'd6,
                         A_MODE = 4'd7, A_PIXCOUNT = 4'd8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } pix_t;

  logic CLK = 1'b0;
  logic RESET;
  logic done;

  gpu_fill_engine_if bus ();

  gpu_fill_engine #(
    .H_RES     (TB_H),
    .V_RES     (TB_V),
    .FB_BASE   (32'h0),
    .BPP_BYTES (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .done  (done)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  pix_t q[$];
  int          cyc = 0;
  int          acc_count = 0;
  int          present_len = 0;
  int          max_present = 0;
  int          first_acc_cyc = 0;
  int          last_acc_cyc = 0;
  logic        first_armed = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_addr, held_data, last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted pixel against the scoreboard and checks
  // that a stalled pixel holds address and data.
  always @(negedge CLK) begin
    pix_t e;
    cyc++;
    if (RESET) begin
      hold_pending = 1'b0;
      present_len  = 0;
    end else if (bus.MASTER_write) begin
      present_len++;
      if (hold_pending) begin
        check("hold_addr", bus.MASTER_address, held_addr);
        check("hold_data", bus.MASTER_writedata, held_data);
      end
      if (!bus.MASTER_waitrequest) begin
        if (present_len > max_present) max_present = present_len;
        present_len  = 0;
        hold_pending = 1'b0;
        acc_count++;
        last_addr    = bus.MASTER_address;
        last_acc_cyc = cyc;
        if (first_armed) begin
          first_acc_cyc = cyc;
          first_armed   = 1'b0;
        end
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                   bus.MASTER_address, bus.MASTER_writedata);
        end else begin
          e = q.pop_front();
          check("pix_addr", bus.MASTER_address, e.addr);
          check("pix_data", bus.MASTER_writedata, e.data);
        end
      end else begin
        hold_pending = 1'b1;
        held_addr    = bus.MASTER_address;
        held_data    = bus.MASTER_writedata;
      end
    end else begin
      hold_pending = 1'b0;
      present_len  = 0;
    end
  end

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    pix_t e;
    e.addr = addr;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge CLK);
    bus.SLAVE_chipselect = 1'b1;
    bus.SLAVE_write      = 1'b1;
    bus.SLAVE_address    = addr;
    bus.SLAVE_writedata  = data;
    @(posedge CLK);
    #1;
    bus.SLAVE_chipselect = 1'b0;
    bus.SLAVE_write      = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge CLK);
    bus.SLAVE_chipselect = 1'b1;
    bus.SLAVE_read       = 1'b1;
    bus.SLAVE_address    = addr;
    @(posedge CLK);
    #1;
    bus.SLAVE_chipselect = 1'b0;
    bus.SLAVE_read       = 1'b0;
    data = bus.SLAVE_readdata;
  endtask

  task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic program_fill(input logic [31:0] mode, input logic [31:0] color,
                              input logic [31:0] x0, input logic [31:0] y0,
                              input logic [31:0] x1, input logic [31:0] y1);
    reg_write(A_MODE, mode);
    reg_write(A_COLOR, color);
    reg_write(A_X0, x0);
    reg_write(A_Y0, y0);
    reg_write(A_X1, x1);
    reg_write(A_Y1, y1);
    reg_write(A_CTRL, 32'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int base;

    RESET                  = 1'b1;
    bus.SLAVE_read         = 1'b0;
    bus.SLAVE_write        = 1'b0;
    bus.SLAVE_chipselect   = 1'b0;
    bus.SLAVE_address      = 4'd0;
    bus.SLAVE_writedata    = 32'd0;
    bus.MASTER_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mwrite", {31'd0, bus.MASTER_write}, 32'd0);
    check("rst_maddr", bus.MASTER_address, 32'd0);
    check("rst_mdata", bus.MASTER_writedata, 32'd0);
    check("rst_rdata", bus.SLAVE_readdata, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    read_check("rst_status", A_STATUS, 32'd0);
    read_check("rst_pixcount", A_PIXCOUNT, 32'd0);

    // Register access: readback, read-only PIXCOUNT, unmapped index
    reg_write(A_COLOR, 32'h1234_5678);
    read_check("color_rb", A_COLOR, 32'h1234_5678);
    reg_write(A_PIXCOUNT, 32'h0000_DEAD);
    read_check("pixcount_ro", A_PIXCOUNT, 32'd0);
    reg_write(4'd12, 32'hFFFF_FFFF);
    read_check("unmapped_rd", 4'd12, 32'd0);

    // Rect (10,20)-(12,21): latency, addresses, STATUS write coinciding with done set
    program_fill(32'd2, 32'hA5A5_A5A5, 32'd10, 32'd20, 32'd12, 32'd21);
    push(32'd51240, 32'hA5A5_A5A5);
    push(32'd51244, 32'hA5A5_A5A5);
    push(32'd51248, 32'hA5A5_A5A5);
    push(32'd53800, 32'hA5A5_A5A5);
    push(32'd53804, 32'hA5A5_A5A5);
    push(32'd53808, 32'hA5A5_A5A5);
    reg_write(A_CTRL, 32'd1);
    check("setup_no_write", {31'd0, bus.MASTER_write}, 32'd0);
    @(posedge CLK);
    #1;
    check("first_write_latency", {31'd0, bus.MASTER_write}, 32'd1);
    check("first_write_addr", bus.MASTER_address, 32'd51240);
    repeat (5) @(posedge CLK);
    #1;
    bus.SLAVE_chipselect = 1'b1;
    bus.SLAVE_write      = 1'b1;
    bus.SLAVE_address    = A_STATUS;
    bus.SLAVE_writedata  = 32'd0;
    @(posedge CLK);
    #1;
    bus.SLAVE_chipselect = 1'b0;
    bus.SLAVE_write      = 1'b0;
    check("set_wins_done", {31'd0, done}, 32'd1);
    read_check("rect_status", A_STATUS, 32'd1);
    read_check("rect_pixcount", A_PIXCOUNT, 32'd6);
    check("rect_q_empty", q.size(), 32'd0);
    reg_write(A_STATUS, 32'd0);
    check("status_clear", {31'd0, done}, 32'd0);

    // Right edge clamp on X1 and bottom clamp on Y1
    program_fill(32'd2, 32'h0BAD_F00D, 32'd638, 32'd31, 32'd700, 32'd479);
    push(32'd81912, 32'h0BAD_F00D);
    push(32'd81916, 32'h0BAD_F00D);
    reg_write(A_CTRL, 32'd1);
    wait_done("clamp", 50);
    read_check("clamp_pixcount", A_PIXCOUNT, 32'd2);
    check("clamp_q_empty", q.size(), 32'd0);
    reg_write(A_STATUS, 32'd0);

    // Waitrequest high for 3 cycles on the 2nd pixel
    program_fill(32'd2, 32'h1122_3344, 32'd0, 32'd1, 32'd3, 32'd1);
    push(32'd2560, 32'h1122_3344);
    push(32'd2564, 32'h1122_3344);
    push(32'd2568, 32'h1122_3344);
    push(32'd2572, 32'h1122_3344);
    max_present = 0;
    base = acc_count;
    reg_write(A_CTRL, 32'd1);
    begin
      int n = 0;
      while (!(bus.MASTER_write && acc_count == base + 1) && n < 20) begin
        @(posedge CLK);
        #1;
        n++;
      end
      check("stall_trigger", {31'd0, bus.MASTER_write && acc_count == base + 1}, 32'd1);
    end
    bus.MASTER_waitrequest = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    bus.MASTER_waitrequest = 1'b0;
    wait_done("stall", 50);
    check("stall_hold_cycles", max_present, 32'd4);
    read_check("stall_pixcount", A_PIXCOUNT, 32'd4);
    check("stall_q_empty", q.size(), 32'd0);
    reg_write(A_STATUS, 32'd0);

    // Empty rectangle: X0 > X1
    program_fill(32'd2, 32'hCAFE_0000, 32'd5, 32'd0, 32'd4, 32'd0);
    base = acc_count;
    reg_write(A_CTRL, 32'd1);
    wait_done("empty", 20);
    check("empty_no_writes", acc_count - base, 32'd0);
    read_check("empty_pixcount", A_PIXCOUNT, 32'd0);
    reg_write(A_STATUS, 32'd0);

    // Start issued while busy must not restart the fill
    program_fill(32'd2, 32'h7777_0001, 32'd0, 32'd2, 32'd5, 32'd2);
    for (int i = 0; i < 6; i++) push(32'd5120 + 32'(4 * i), 32'h7777_0001);
    bus.MASTER_waitrequest = 1'b1;
    reg_write(A_CTRL, 32'd1);
    reg_write(A_CTRL, 32'd0);
    reg_write(A_CTRL, 32'd1);
    read_check("busy_status", A_STATUS, 32'd2);
    bus.MASTER_waitrequest = 1'b0;
    wait_done("busy_start", 50);
    repeat (10) @(posedge CLK);
    #1;
    read_check("busy_pixcount", A_PIXCOUNT, 32'd6);
    read_check("busy_final_status", A_STATUS, 32'd1);
    check("busy_q_empty", q.size(), 32'd0);
    reg_write(A_STATUS, 32'd0);

    // Full clear of the 640x32 framebuffer
    program_fill(32'd1, 32'h00FF_00FF, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < TB_H * TB_V; i++) push(32'(4 * i), 32'h00FF_00FF);
    base = acc_count;
    first_armed = 1'b1;
    reg_write(A_CTRL, 32'd1);
    wait_done("clear", 25000);
    check("clear_writes", acc_count - base, 32'(TB_H * TB_V));
    check("clear_last_addr", last_addr, 32'h0001_3FFC);
    check("clear_throughput", last_acc_cyc - first_acc_cyc, 32'(TB_H * TB_V - 1));
    read_check("clear_pixcount", A_PIXCOUNT, 32'(TB_H * TB_V));
    check("clear_q_empty", q.size(), 32'd0);

    // Reset mid-fill (done left set from the clear so the reset must drop it)
    reg_write(A_MODE, 32'd2);
    reg_write(A_COLOR, 32'h3C3C_3C3C);
    reg_write(A_X0, 32'd0);
    reg_write(A_Y0, 32'd0);
    reg_write(A_X1, 32'd639);
    reg_write(A_Y1, 32'd3);
    reg_write(A_CTRL, 32'd0);
    for (int i = 0; i < 4 * TB_H; i++) push(32'(4 * i), 32'h3C3C_3C3C);
    reg_write(A_CTRL, 32'd1);
    repeat (100) @(posedge CLK);
    #2;
    check("pre_reset_writing", {31'd0, bus.MASTER_write}, 32'd1);
    RESET = 1'b1;
    q.delete();
    #1;
    check("reset_mwrite", {31'd0, bus.MASTER_write}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_maddr", bus.MASTER_address, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    base = acc_count;
    repeat (10) @(posedge CLK);
    #1;
    check("reset_no_writes", acc_count - base, 32'd0);
    read_check("reset_mode", A_MODE, 32'd0);
    read_check("reset_pixcount", A_PIXCOUNT, 32'd0);

    // Fresh fill after reset
    program_fill(32'd2, 32'h55AA_55AA, 32'd10, 32'd20, 32'd12, 32'd21);
    push(32'd51240, 32'h55AA_55AA);
    push(32'd51244, 32'h55AA_55AA);
    push(32'd51248, 32'h55AA_55AA);
    push(32'd53800, 32'h55AA_55AA);
    push(32'd53804, 32'h55AA_55AA);
    push(32'd53808, 32'h55AA_55AA);
    reg_write(A_CTRL, 32'd1);
    wait_done("post_reset", 50);
    read_check("post_reset_pixcount", A_PIXCOUNT, 32'd6);
    check("post_reset_q_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_fill_engine.md
GPU_FILL_ENGINE -- requirements
Module: gpu_fill_engine

Interface
REQ-001 SHALL have parameter H_RES, default 640, framebuffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, framebuffer height in pixels.
REQ-003 SHALL have parameter FB_BASE, default 0, byte address of pixel (0,0).
REQ-004 SHALL have parameter BPP_BYTES, default 4, byte stride per pixel.
REQ-005 SHALL have ports: CLK in 1 clock; RESET in 1, asynchronous active-high; the reset polarity and synchronicity are fixed.
REQ-006 SHALL have ports: SLAVE_read in 1; SLAVE_write in 1; SLAVE_chipselect in 1; SLAVE_address in 4 word index; SLAVE_writedata in 32; SLAVE_readdata out 32.
REQ-007 SHALL have ports: MASTER_write out 1; MASTER_address out 32 byte address; MASTER_writedata out 32 pixel colour; MASTER_waitrequest in 1.
REQ-008 SHALL have port done out 1, mirroring STATUS.done.

Function
REQ-009 Register map (word index): 0 CTRL (bit0 start); 1 STATUS (bit0 done, bit1 busy; any write clears done); 2 COLOR; 3 X0; 4 Y0; 5 X1; 6 Y1; 7 MODE (0 none, 1 clear, 2 rect); 8 PIXCOUNT (read-only).
REQ-010 Slave writes SHALL take effect when chipselect and write are high at the CLK edge; writes to 0–7 outside these rules and writes to index 8 or 9–15 SHALL be ignored.
REQ-011 Slave reads SHALL return data one cycle after chipselect and read are sampled high; unmapped indices SHALL read 0.
REQ-012 FSM states SHALL be IDLE, SETUP, WRITE, DONE.
REQ-013 IDLE→SETUP SHALL occur on a rising edge of CTRL.start (0→1 write); a start while busy SHALL be ignored.
REQ-014 SETUP SHALL latch COLOR and the bounds: mode 1 uses (0,0)–(H_RES-1,V_RES-1); mode 2 uses X0..X1, Y0..Y1 with X1 clamped to H_RES-1 and Y1 to V_RES-1.
REQ-015 Mode 0, X0>X1, Y0>Y1, X0>=H_RES, or Y0>=V_RES after clamping SHALL go SETUP→DONE with zero writes.
REQ-016 WRITE SHALL assert MASTER_write with MASTER_address = FB_BASE + (y*H_RES + x)*BPP_BYTES, raster order: x fastest, then y.
REQ-017 While MASTER_waitrequest is high, address, data, and write SHALL hold stable; a pixel advances only on a cycle with write high and waitrequest low.
REQ-018 With waitrequest held low, throughput SHALL be one pixel per cycle; first write SHALL appear 2 cycles after the start write.
REQ-019 PIXCOUNT SHALL clear in SETUP and increment per accepted pixel, 32-bit.
REQ-020 After the last pixel is accepted, the FSM SHALL enter DONE, set done, clear busy, then return to IDLE; done stays set until a STATUS write.
REQ-021 A STATUS write on the same cycle that done is set SHALL leave done set (set wins).
REQ-022 Address arithmetic SHALL be 32-bit unsigned; row offset SHALL be maintained by adding H_RES*BPP_BYTES per row, with no multiplier in the pixel loop.

Reset
REQ-023 RESET SHALL asynchronously force IDLE, all registers to 0, MASTER_write=0, MASTER_address=0, MASTER_writedata=0, SLAVE_readdata=0, and done=0.
REQ-024 RESET during WRITE SHALL abort the fill immediately; no further writes SHALL occur.

Structure
REQ-025 The register index constants, the mode enum, and the FSM state enum SHALL reside in package gpu_fill_pkg.
REQ-026 The x/y raster counter with row-offset accumulation SHALL be a sub-module, fill_raster_counter.

Verification
REQ-027 Mode 1, COLOR=0x00FF00FF, waitrequest=0: exactly 307200 writes, last address 0x0012BFFC, PIXCOUNT=307200, done=1.
REQ-028 Mode 2, (10,20)–(12,21): six writes at byte addresses 51240, 51244, 51248, 53800, 53804, 53808.
REQ-029 Mode 2, X1=700, Y1=479, X0=638, Y0=479: two writes, at x=638 and x=639 only.
REQ-030 Waitrequest high for 3 cycles on the 2nd pixel: address and data held stable for 4 cycles, with no skipped or duplicated pixel.
REQ-031 X0=5, X1=4: done=1 with zero writes; a start issued while busy yields no restart.
REQ-032 RESET asserted mid-fill: MASTER_write=0 and done=0 immediately; a subsequent start completes normally.
